// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial A - B - BIN subtractor, one 4-bit digit per clock.
// Optional two's-complement overflow output enabled by defining SUB_OVF_EN.
module nibble_serial_sub #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 bin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 bout,
  output logic                 zero
`ifdef SUB_OVF_EN
  , output logic               ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [IW-1:0] index_q, index_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d, done_q, done_d, bout_q, bout_d, zero_q, zero_d;
  logic [3:0]    a_nib, b_nib;
  logic [4:0]    sum;
`ifdef SUB_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  // Subtraction as A + ~B + carry, where the carry starts as ~bin.
  always_comb begin
    a_nib = a_q[4*index_q +: 4];
    b_nib = b_q[4*index_q +: 4];
    sum   = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    index_d = index_q;
    carry_d = carry_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bout_d  = bout_q;
    zero_d  = zero_q;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          index_d = '0;
          diff_d  = '0;
          bout_d  = 1'b0;
          zero_d  = 1'b0;
`ifdef SUB_OVF_EN
          ovf_d   = 1'b0;
`endif
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[4*index_q +: 4] = sum[3:0];
        carry_d = sum[4];
        index_d = index_q + 1'b1;
        if (index_q == LAST) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        bout_d  = ~carry_q;
        zero_d  = (diff_q == '0);
`ifdef SUB_OVF_EN
        ovf_d   = (a_q[W-1] != b_q[W-1]) && (diff_q[W-1] != a_q[W-1]);
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      index_q <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      index_q <= index_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
`ifdef SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb/tb_nibble_serial_sub.sv - directed and random bench for nibble_serial_sub against an arithmetic model.
module tb_nibble_serial_sub;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n, start, bin;
  logic [W-1:0] a, b;
  logic         busy, done, bout, zero;
  logic [W-1:0] diff;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_sub #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero)
`ifdef SUB_OVF_EN
    , .ovf (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts one subtraction and checks the full timeline; inj > 0 pulses a stray start with junk operands before edge inj.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic bi_n, input int inj);
    longint       d, sa, sb, sr;
    logic [W-1:0] ed;
    logic         eb, eo;
    d  = longint'(ai) - longint'(bi) - longint'(bi_n);
    ed = W'(d);
    eb = (d < 0);
    sa = ai[W-1] ? longint'(ai) - (longint'(1) << W) : longint'(ai);
    sb = bi[W-1] ? longint'(bi) - (longint'(1) << W) : longint'(bi);
    sr = sa - sb - longint'(bi_n);
    eo = (sr < -(longint'(1) << (W-1))) || (sr >= (longint'(1) << (W-1)));
    @(negedge clk);
    a = ai; b = bi; bin = bi_n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    check("busy_on_accept", busy, 1);
    check("done_on_accept", done, 0);
    check("bout_cleared", bout, 0);
    for (int k = 1; k <= N + 1; k++) begin
      if (k == inj) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_timeline", busy, (k < N) ? 1 : 0);
      check("done_timeline", done, (k == N + 1) ? 1 : 0);
    end
    check("diff", diff, ed);
    check("bout", bout, eb);
    check("zero", zero, (ed == '0) ? 1 : 0);
`ifdef SUB_OVF_EN
    check("ovf", ovf, eo);
`else
    if (eo) ;
`endif
    @(posedge clk); #1;
    check("done_single_pulse", done, 0);
    check("diff_hold", diff, ed);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0234, 1'b0, -1);
    run_op(16'h0000, 16'h0001, 1'b0, -1);
    run_op(16'h0005, 16'h0004, 1'b1, -1);
    run_op(16'h8000, 16'h0001, 1'b0, -1);
    run_op(16'h0003, 16'h0001, 1'b0, -1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, -1);
    run_op(16'h0000, 16'h0000, 1'b0, -1);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, -1);
    run_op(16'hA5A5, 16'h1111, 1'b0, 2);

    // Abort mid-run with an asynchronous reset pulse.
    @(negedge clk);
    a = 16'h4321; b = 16'h1234; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_diff", diff, 0);
    check("abort_done", done, 0);
    check("abort_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", done, 0);
    end
    run_op(16'h00FF, 16'h000F, 1'b0, -1);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), (i % 5 == 0) ? 3 : -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
